// File: rtl/avmm_burst_arbiter.sv
// Round-robin Avalon-MM arbiter: N masters share one slave, write bursts lock the grant,
// and read responses are routed back in order through a pending-read FIFO.
module avmm_burst_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_W      = 12,
    parameter int SYMBOL_W    = 8,
    parameter int NUM_SYMBOLS = 4,
    parameter int BURST_W     = 4,
    parameter int MAX_PENDING = 8,
    localparam int DATA_W     = SYMBOL_W * NUM_SYMBOLS
) (
    input  logic                            clk_clk,
    input  logic                            reset_reset_n,
    input  logic [NUM_MASTERS*ADDR_W-1:0]   m_address,
    input  logic [NUM_MASTERS-1:0]          m_read,
    input  logic [NUM_MASTERS-1:0]          m_write,
    input  logic [NUM_MASTERS*DATA_W-1:0]   m_writedata,
    input  logic [NUM_MASTERS*NUM_SYMBOLS-1:0] m_byteenable,
    input  logic [NUM_MASTERS*BURST_W-1:0]  m_burstcount,
    output logic [NUM_MASTERS-1:0]          m_waitrequest,
    output logic [NUM_MASTERS-1:0]          m_readdatavalid,
    output logic [DATA_W-1:0]               m_readdata,
    output logic [ADDR_W-1:0]               s_address,
    output logic                            s_read,
    output logic                            s_write,
    output logic [DATA_W-1:0]               s_writedata,
    output logic [NUM_SYMBOLS-1:0]          s_byteenable,
    output logic [BURST_W-1:0]              s_burstcount,
    input  logic                            s_waitrequest,
    input  logic                            s_readdatavalid,
    input  logic [DATA_W-1:0]               s_readdata
);
    localparam int MID_W = $clog2(NUM_MASTERS);
    localparam int PTR_W = (MAX_PENDING > 1) ? $clog2(MAX_PENDING) : 1;
    localparam int CNT_W = $clog2(MAX_PENDING + 1);

    typedef enum logic {IDLE = 1'b0, WBURST = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [MID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [MID_W-1:0]   lock_q, lock_d;
    logic [BURST_W-1:0] wcnt_q, wcnt_d;
    logic [BURST_W-1:0] rbeat_q, rbeat_d;
    logic [MID_W-1:0]   fifo_id_q  [MAX_PENDING];
    logic [BURST_W-1:0] fifo_len_q [MAX_PENDING];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic               err_q;

    logic                   fifo_full, fifo_empty;
    logic [NUM_MASTERS-1:0] eligible;
    logic                   gnt_valid;
    logic [MID_W-1:0]       gnt, cand;
    logic                   accept, push, pop, rsp_hit;
    logic [BURST_W-1:0]     push_len;
    logic [MID_W-1:0]       head_id;
    logic [BURST_W-1:0]     head_len;

    assign fifo_full  = (count_q == CNT_W'(MAX_PENDING));
    assign fifo_empty = (count_q == '0);

    // Fullness is taken from the registered count, so a same-cycle pop never frees a read slot.
    always_comb begin
        eligible  = m_write | (m_read & {NUM_MASTERS{~fifo_full}});
        gnt_valid = 1'b0;
        gnt       = '0;
        cand      = '0;
        if (state_q == WBURST) begin
            gnt_valid = 1'b1;
            gnt       = lock_q;
        end else begin
            for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
                cand = MID_W'((32'(rr_ptr_q) + i) % NUM_MASTERS);
                if (!gnt_valid && eligible[cand]) begin
                    gnt_valid = 1'b1;
                    gnt       = cand;
                end
            end
        end
        gnt_valid = gnt_valid & reset_reset_n;
    end

    always_comb begin
        s_address     = '0;
        s_read        = 1'b0;
        s_write       = 1'b0;
        s_writedata   = '0;
        s_byteenable  = '0;
        s_burstcount  = '0;
        m_waitrequest = '1;
        if (gnt_valid) begin
            s_address          = m_address[gnt*ADDR_W +: ADDR_W];
            s_writedata        = m_writedata[gnt*DATA_W +: DATA_W];
            s_byteenable       = m_byteenable[gnt*NUM_SYMBOLS +: NUM_SYMBOLS];
            s_burstcount       = m_burstcount[gnt*BURST_W +: BURST_W];
            s_write            = m_write[gnt];
            s_read             = m_read[gnt] & ~m_write[gnt] & (state_q == IDLE);
            m_waitrequest[gnt] = s_waitrequest;
        end
    end

    assign accept   = (s_read | s_write) & ~s_waitrequest;
    assign push     = accept & s_read;
    assign push_len = (s_burstcount == '0) ? BURST_W'(1) : s_burstcount;
    assign head_id  = fifo_id_q[rd_ptr_q];
    assign head_len = fifo_len_q[rd_ptr_q];
    assign rsp_hit  = s_readdatavalid & ~fifo_empty;
    assign pop      = rsp_hit & ((rbeat_q + BURST_W'(1)) == head_len);
    assign m_readdata = s_readdata;

    always_comb begin
        m_readdatavalid = '0;
        if (rsp_hit) m_readdatavalid[head_id] = 1'b1;
    end

    always_comb begin
        state_d  = state_q;
        lock_d   = lock_q;
        wcnt_d   = wcnt_q;
        rr_ptr_d = rr_ptr_q;
        rbeat_d  = rbeat_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (s_write && (s_burstcount > BURST_W'(1))) begin
                        state_d = WBURST;
                        lock_d  = gnt;
                        wcnt_d  = s_burstcount - BURST_W'(1);
                    end else begin
                        rr_ptr_d = (gnt == MID_W'(NUM_MASTERS - 1)) ? '0 : gnt + 1'b1;
                    end
                end
            end
            WBURST: begin
                if (accept) begin
                    if (wcnt_q == BURST_W'(1)) begin
                        state_d  = IDLE;
                        wcnt_d   = '0;
                        rr_ptr_d = (lock_q == MID_W'(NUM_MASTERS - 1)) ? '0 : lock_q + 1'b1;
                    end else begin
                        wcnt_d = wcnt_q - BURST_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (rsp_hit) rbeat_d = pop ? '0 : rbeat_q + BURST_W'(1);
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            lock_q   <= '0;
            wcnt_q   <= '0;
            rbeat_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
            for (int unsigned i = 0; i < MAX_PENDING; i++) begin
                fifo_id_q[i]  <= '0;
                fifo_len_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            lock_q   <= lock_d;
            wcnt_q   <= wcnt_d;
            rbeat_q  <= rbeat_d;
            if (push) begin
                fifo_id_q[wr_ptr_q]  <= gnt;
                fifo_len_q[wr_ptr_q] <= push_len;
                wr_ptr_q <= (wr_ptr_q == PTR_W'(MAX_PENDING - 1)) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == PTR_W'(MAX_PENDING - 1)) ? '0 : rd_ptr_q + 1'b1;
            end
            if (push && !pop) count_q <= count_q + 1'b1;
            else if (pop && !push) count_q <= count_q - 1'b1;
            if (s_readdatavalid && fifo_empty) err_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_avmm_burst_arbiter.sv
// Directed bench for avmm_burst_arbiter with two masters and default parameters.
module tb_avmm_burst_arbiter;
    localparam int NM = 2, AW = 12, DW = 32, NS = 4, BW = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NM*AW-1:0]  m_address;
    logic [NM-1:0]     m_read, m_write;
    logic [NM*DW-1:0]  m_writedata;
    logic [NM*NS-1:0]  m_byteenable;
    logic [NM*BW-1:0]  m_burstcount;
    logic [NM-1:0]     m_waitrequest, m_readdatavalid;
    logic [DW-1:0]     m_readdata;
    logic [AW-1:0]     s_address;
    logic              s_read, s_write;
    logic [DW-1:0]     s_writedata;
    logic [NS-1:0]     s_byteenable;
    logic [BW-1:0]     s_burstcount;
    logic              s_waitrequest, s_readdatavalid;
    logic [DW-1:0]     s_readdata;

    int checks = 0;
    int passed = 0;
    int acc_cnt = 0;

    avmm_burst_arbiter #(
        .NUM_MASTERS(NM), .ADDR_W(AW), .SYMBOL_W(8), .NUM_SYMBOLS(NS), .BURST_W(BW), .MAX_PENDING(8)
    ) dut (
        .clk_clk(clk), .reset_reset_n(rst_n),
        .m_address(m_address), .m_read(m_read), .m_write(m_write),
        .m_writedata(m_writedata), .m_byteenable(m_byteenable), .m_burstcount(m_burstcount),
        .m_waitrequest(m_waitrequest), .m_readdatavalid(m_readdatavalid), .m_readdata(m_readdata),
        .s_address(s_address), .s_read(s_read), .s_write(s_write), .s_writedata(s_writedata),
        .s_byteenable(s_byteenable), .s_burstcount(s_burstcount),
        .s_waitrequest(s_waitrequest), .s_readdatavalid(s_readdatavalid), .s_readdata(s_readdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (rst_n && s_write && !s_waitrequest && s_address == 12'h200) acc_cnt <= acc_cnt + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, checks done %0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(input int k, input logic rd, input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [BW-1:0] bc);
        m_read[k]                = rd;
        m_write[k]               = wr;
        m_address[k*AW +: AW]    = a;
        m_writedata[k*DW +: DW]  = d;
        m_byteenable[k*NS +: NS] = (rd | wr) ? 4'hF : 4'h0;
        m_burstcount[k*BW +: BW] = bc;
    endtask

    task automatic clear_inputs();
        set_m(0, 1'b0, 1'b0, '0, '0, '0);
        set_m(1, 1'b0, 1'b0, '0, '0, '0);
        s_waitrequest   = 1'b0;
        s_readdatavalid = 1'b0;
        s_readdata      = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        set_m(0, 1'b0, 1'b1, 12'h011, 32'h1, 4'd1);
        set_m(1, 1'b1, 1'b0, 12'h022, 32'h0, 4'd1);
        s_readdatavalid = 1'b1;
        #2;
        checks++; if (s_write !== 1'b0) $display("FAIL rst_s_write: got %b want 0", s_write); else passed++;
        checks++; if (s_read !== 1'b0) $display("FAIL rst_s_read: got %b want 0", s_read); else passed++;
        checks++; if (m_waitrequest !== 2'b11) $display("FAIL rst_m_waitrequest: got %b want 11", m_waitrequest); else passed++;
        checks++; if (m_readdatavalid !== 2'b00) $display("FAIL rst_m_rdv: got %b want 00", m_readdatavalid); else passed++;
        tick();
        tick();
        clear_inputs();
        rst_n = 1'b1;
        #1;
        checks++; if (dut.rr_ptr_q !== 1'b0) $display("FAIL rst_rr_ptr: got %0d want 0", dut.rr_ptr_q); else passed++;
        checks++; if (dut.err_q !== 1'b0) $display("FAIL rst_err: got %b want 0", dut.err_q); else passed++;
        checks++; if (s_address !== 12'h000) $display("FAIL rst_s_address: got %h want 000", s_address); else passed++;
    endtask

    task automatic test_rr_writes();
        set_m(0, 1'b0, 1'b1, 12'h010, 32'h1111_0000, 4'd1);
        set_m(1, 1'b0, 1'b1, 12'h020, 32'h2222_0000, 4'd1);
        #1;
        checks++; if (s_write !== 1'b1 || s_address !== 12'h010) $display("FAIL rr_c0_cmd: got w=%b a=%h want w=1 a=010", s_write, s_address); else passed++;
        checks++; if (s_writedata !== 32'h1111_0000) $display("FAIL rr_c0_wdata: got %h want 11110000", s_writedata); else passed++;
        checks++; if (s_byteenable !== 4'hF || s_burstcount !== 4'd1) $display("FAIL rr_c0_be_bc: got be=%h bc=%0d want be=f bc=1", s_byteenable, s_burstcount); else passed++;
        checks++; if (m_waitrequest !== 2'b10) $display("FAIL rr_c0_waitreq: got %b want 10", m_waitrequest); else passed++;
        tick();
        set_m(0, 1'b0, 1'b0, '0, '0, '0);
        #1;
        checks++; if (dut.rr_ptr_q !== 1'b1) $display("FAIL rr_c1_ptr: got %0d want 1", dut.rr_ptr_q); else passed++;
        checks++; if (s_address !== 12'h020 || s_writedata !== 32'h2222_0000) $display("FAIL rr_c1_cmd: got a=%h d=%h want a=020 d=22220000", s_address, s_writedata); else passed++;
        checks++; if (m_waitrequest !== 2'b01) $display("FAIL rr_c1_waitreq: got %b want 01", m_waitrequest); else passed++;
        tick();
        set_m(1, 1'b0, 1'b0, '0, '0, '0);
        #1;
        checks++; if (dut.rr_ptr_q !== 1'b0) $display("FAIL rr_end_ptr: got %0d want 0", dut.rr_ptr_q); else passed++;
        checks++; if (s_write !== 1'b0 || s_address !== 12'h000 || m_waitrequest !== 2'b11) $display("FAIL rr_idle: got w=%b a=%h wr=%b want w=0 a=000 wr=11", s_write, s_address, m_waitrequest); else passed++;
    endtask

    task automatic test_wburst();
        set_m(1, 1'b0, 1'b1, 12'h100, 32'hB000_0000, 4'd4);
        #1;
        checks++; if (s_write !== 1'b1 || s_address !== 12'h100 || s_burstcount !== 4'd4) $display("FAIL wb_first: got w=%b a=%h bc=%0d want w=1 a=100 bc=4", s_write, s_address, s_burstcount); else passed++;
        checks++; if (m_waitrequest !== 2'b01) $display("FAIL wb_first_waitreq: got %b want 01", m_waitrequest); else passed++;
        tick();
        for (int b = 1; b < 4; b++) begin
            set_m(1, 1'b0, 1'b1, 12'h100, 32'hB000_0000 + 32'(b), 4'd4);
            set_m(0, 1'b1, 1'b0, 12'h040, '0, 4'd1);
            #1;
            checks++; if (s_write !== 1'b1 || s_read !== 1'b0 || s_address !== 12'h100) $display("FAIL wb_beat%0d_cmd: got w=%b r=%b a=%h want w=1 r=0 a=100", b, s_write, s_read, s_address); else passed++;
            checks++; if (s_writedata !== 32'hB000_0000 + 32'(b)) $display("FAIL wb_beat%0d_wdata: got %h want %h", b, s_writedata, 32'hB000_0000 + 32'(b)); else passed++;
            checks++; if (m_waitrequest !== 2'b01) $display("FAIL wb_beat%0d_waitreq: got %b want 01", b, m_waitrequest); else passed++;
            tick();
        end
        set_m(1, 1'b0, 1'b0, '0, '0, '0);
        #1;
        checks++; if (dut.state_q !== 1'b0 || dut.rr_ptr_q !== 1'b0) $display("FAIL wb_after_state: got st=%0d ptr=%0d want st=0 ptr=0", dut.state_q, dut.rr_ptr_q); else passed++;
        checks++; if (s_read !== 1'b1 || s_address !== 12'h040 || m_waitrequest !== 2'b10) $display("FAIL wb_read_issue: got r=%b a=%h wr=%b want r=1 a=040 wr=10", s_read, s_address, m_waitrequest); else passed++;
        tick();
        set_m(0, 1'b0, 1'b0, '0, '0, '0);
        s_readdatavalid = 1'b1;
        s_readdata      = 32'hDEAD_BEEF;
        #1;
        checks++; if (m_readdatavalid !== 2'b01 || m_readdata !== 32'hDEAD_BEEF) $display("FAIL wb_rsp: got v=%b d=%h want v=01 d=deadbeef", m_readdatavalid, m_readdata); else passed++;
        tick();
        s_readdatavalid = 1'b0;
        #1;
        checks++; if (dut.count_q !== 4'd0) $display("FAIL wb_fifo_count: got %0d want 0", dut.count_q); else passed++;
    endtask

    task automatic test_read_routing();
        int gap;
        set_m(0, 1'b1, 1'b0, 12'h050, '0, 4'd8);
        #1;
        checks++; if (s_read !== 1'b1 || s_burstcount !== 4'd8 || s_address !== 12'h050) $display("FAIL rd_m0_cmd: got r=%b bc=%0d a=%h want r=1 bc=8 a=050", s_read, s_burstcount, s_address); else passed++;
        tick();
        set_m(0, 1'b0, 1'b0, '0, '0, '0);
        set_m(1, 1'b1, 1'b0, 12'h080, '0, 4'd2);
        #1;
        checks++; if (s_read !== 1'b1 || s_address !== 12'h080 || m_waitrequest !== 2'b01) $display("FAIL rd_m1_cmd: got r=%b a=%h wr=%b want r=1 a=080 wr=01", s_read, s_address, m_waitrequest); else passed++;
        tick();
        set_m(1, 1'b0, 1'b0, '0, '0, '0);
        #1;
        checks++; if (dut.count_q !== 4'd2) $display("FAIL rd_pending: got %0d want 2", dut.count_q); else passed++;
        for (int i = 0; i < 10; i++) begin
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) begin
                s_readdatavalid = 1'b0;
                #1;
                checks++; if (m_readdatavalid !== 2'b00) $display("FAIL rd_gap%0d: got %b want 00", i, m_readdatavalid); else passed++;
                tick();
            end
            s_readdatavalid = 1'b1;
            s_readdata      = 32'hA5A5_0000 + 32'(i);
            #1;
            checks++; if (m_readdatavalid !== ((i < 8) ? 2'b01 : 2'b10)) $display("FAIL rd_beat%0d_route: got %b want %b", i, m_readdatavalid, (i < 8) ? 2'b01 : 2'b10); else passed++;
            checks++; if (m_readdata !== 32'hA5A5_0000 + 32'(i)) $display("FAIL rd_beat%0d_data: got %h want %h", i, m_readdata, 32'hA5A5_0000 + 32'(i)); else passed++;
            tick();
        end
        s_readdatavalid = 1'b0;
        #1;
        checks++; if (dut.count_q !== 4'd0) $display("FAIL rd_drained: got %0d want 0", dut.count_q); else passed++;
    endtask

    task automatic test_pending_full();
        set_m(0, 1'b1, 1'b0, 12'h060, '0, 4'd1);
        repeat (8) tick();
        checks++; if (dut.count_q !== 4'd8) $display("FAIL full_count: got %0d want 8", dut.count_q); else passed++;
        checks++; if (s_read !== 1'b0 || m_waitrequest !== 2'b11) $display("FAIL full_hold: got r=%b wr=%b want r=0 wr=11", s_read, m_waitrequest); else passed++;
        set_m(1, 1'b0, 1'b1, 12'h300, 32'h3000_0001, 4'd1);
        #1;
        checks++; if (s_write !== 1'b1 || s_address !== 12'h300 || m_waitrequest !== 2'b01) $display("FAIL full_write: got w=%b a=%h wr=%b want w=1 a=300 wr=01", s_write, s_address, m_waitrequest); else passed++;
        tick();
        set_m(1, 1'b0, 1'b0, '0, '0, '0);
        s_readdatavalid = 1'b1;
        s_readdata      = 32'h0000_0F00;
        #1;
        checks++; if (m_readdatavalid !== 2'b01) $display("FAIL full_rsp: got %b want 01", m_readdatavalid); else passed++;
        checks++; if (s_read !== 1'b0 || m_waitrequest !== 2'b11) $display("FAIL full_pop_same_cycle: got r=%b wr=%b want r=0 wr=11", s_read, m_waitrequest); else passed++;
        tick();
        s_readdatavalid = 1'b0;
        #1;
        checks++; if (s_read !== 1'b1 || m_waitrequest !== 2'b10) $display("FAIL full_slot_freed: got r=%b wr=%b want r=1 wr=10", s_read, m_waitrequest); else passed++;
        tick();
        set_m(0, 1'b0, 1'b0, '0, '0, '0);
        for (int i = 0; i < 8; i++) begin
            if (i == 7) set_m(0, 1'b1, 1'b0, 12'h070, '0, 4'd1);
            s_readdatavalid = 1'b1;
            s_readdata      = 32'h0000_0F10 + 32'(i);
            #1;
            checks++; if (m_readdatavalid !== 2'b01) $display("FAIL full_drain%0d: got %b want 01", i, m_readdatavalid); else passed++;
            tick();
        end
        set_m(0, 1'b0, 1'b0, '0, '0, '0);
        s_readdatavalid = 1'b0;
        #1;
        checks++; if (dut.count_q !== 4'd1) $display("FAIL push_pop_count: got %0d want 1", dut.count_q); else passed++;
        s_readdatavalid = 1'b1;
        tick();
        s_readdatavalid = 1'b0;
        #1;
        checks++; if (dut.count_q !== 4'd0) $display("FAIL full_final_empty: got %0d want 0", dut.count_q); else passed++;
    endtask

    task automatic test_wait_burst();
        int base;
        base = acc_cnt;
        for (int b = 0; b < 3; b++) begin
            set_m(0, 1'b0, 1'b1, 12'h200, 32'hC000_0000 + 32'(b), 4'd3);
            if (b == 1) set_m(1, 1'b0, 1'b1, 12'h304, 32'h3333_0000, 4'd1);
            s_waitrequest = 1'b1;
            for (int s = 0; s < 2; s++) begin
                #1;
                checks++; if (s_write !== 1'b1 || s_address !== 12'h200 || s_writedata !== 32'hC000_0000 + 32'(b)) $display("FAIL ws_b%0d_s%0d_cmd: got w=%b a=%h d=%h want w=1 a=200 d=%h", b, s, s_write, s_address, s_writedata, 32'hC000_0000 + 32'(b)); else passed++;
                checks++; if (m_waitrequest !== 2'b11) $display("FAIL ws_b%0d_s%0d_waitreq: got %b want 11", b, s, m_waitrequest); else passed++;
                tick();
            end
            s_waitrequest = 1'b0;
            #1;
            checks++; if (m_waitrequest !== 2'b10) $display("FAIL ws_b%0d_accept: got %b want 10", b, m_waitrequest); else passed++;
            tick();
        end
        set_m(0, 1'b0, 1'b0, '0, '0, '0);
        #1;
        checks++; if (acc_cnt - base !== 3) $display("FAIL ws_beats: got %0d want 3", acc_cnt - base); else passed++;
        checks++; if (dut.state_q !== 1'b0 || dut.rr_ptr_q !== 1'b1) $display("FAIL ws_end_state: got st=%0d ptr=%0d want st=0 ptr=1", dut.state_q, dut.rr_ptr_q); else passed++;
        checks++; if (s_address !== 12'h304 || m_waitrequest !== 2'b01) $display("FAIL ws_next_grant: got a=%h wr=%b want a=304 wr=01", s_address, m_waitrequest); else passed++;
        tick();
        set_m(1, 1'b0, 1'b0, '0, '0, '0);
        #1;
        checks++; if (dut.rr_ptr_q !== 1'b0) $display("FAIL ws_final_ptr: got %0d want 0", dut.rr_ptr_q); else passed++;
    endtask

    task automatic test_reset_midburst();
        set_m(1, 1'b1, 1'b0, 12'h0A0, '0, 4'd2);
        repeat (3) tick();
        set_m(1, 1'b0, 1'b0, '0, '0, '0);
        #1;
        checks++; if (dut.count_q !== 4'd3) $display("FAIL mr_pending: got %0d want 3", dut.count_q); else passed++;
        set_m(0, 1'b0, 1'b1, 12'h400, 32'hD000_0000, 4'd8);
        tick();
        set_m(0, 1'b0, 1'b1, 12'h400, 32'hD000_0001, 4'd8);
        s_waitrequest = 1'b1;
        #1;
        checks++; if (dut.state_q !== 1'b1) $display("FAIL mr_in_burst: got %0d want 1", dut.state_q); else passed++;
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (dut.state_q !== 1'b0 || dut.count_q !== 4'd0) $display("FAIL mr_reset_state: got st=%0d cnt=%0d want st=0 cnt=0", dut.state_q, dut.count_q); else passed++;
        checks++; if (s_write !== 1'b0 || s_read !== 1'b0 || m_waitrequest !== 2'b11 || m_readdatavalid !== 2'b00) $display("FAIL mr_reset_outputs: got w=%b r=%b wr=%b v=%b want w=0 r=0 wr=11 v=00", s_write, s_read, m_waitrequest, m_readdatavalid); else passed++;
        clear_inputs();
        tick();
        rst_n = 1'b1;
        #1;
        checks++; if (dut.err_q !== 1'b0 || s_write !== 1'b0) $display("FAIL mr_release: got err=%b w=%b want err=0 w=0", dut.err_q, s_write); else passed++;
        s_readdatavalid = 1'b1;
        s_readdata      = 32'hBAD0_0001;
        #1;
        checks++; if (m_readdatavalid !== 2'b00) $display("FAIL mr_stray_routed: got %b want 00", m_readdatavalid); else passed++;
        tick();
        s_readdatavalid = 1'b0;
        #1;
        checks++; if (dut.err_q !== 1'b1) $display("FAIL mr_err_flag: got %b want 1", dut.err_q); else passed++;
        checks++; if (dut.count_q !== 4'd0 || dut.state_q !== 1'b0) $display("FAIL mr_after_stray: got cnt=%0d st=%0d want cnt=0 st=0", dut.count_q, dut.state_q); else passed++;
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_rr_writes();
        test_wburst();
        test_read_routing();
        test_pending_full();
        test_wait_burst();
        test_reset_midburst();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/avmm_burst_arbiter.md
AVMM_BURST_ARBITER -- requirements
Module: avmm_burst_arbiter

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 2, number of Avalon-MM master ports (2..8).
REQ-002 SHALL have parameter ADDR_W, default 12, address width.
REQ-003 SHALL have parameters SYMBOL_W, default 8, and NUM_SYMBOLS, default 4; DATA_W = SYMBOL_W*NUM_SYMBOLS.
REQ-004 SHALL have parameter BURST_W, default 4, burstcount width (max burst 2^(BURST_W-1)).
REQ-005 SHALL have parameter MAX_PENDING, default 8, depth of the outstanding-read tracking FIFO.
REQ-006 SHALL have ports: clk_clk  in  1  single clock, all logic on rising edge.
REQ-007 SHALL have: reset_reset_n  in  1  asynchronous, active-low reset.
REQ-008 SHALL have: m_address  in  NUM_MASTERS*ADDR_W  per-master address, master k at slice k.
REQ-009 SHALL have: m_read, m_write  in  NUM_MASTERS each  per-master request strobes.
REQ-010 SHALL have: m_writedata  in  NUM_MASTERS*DATA_W; m_byteenable  in  NUM_MASTERS*NUM_SYMBOLS; m_burstcount  in  NUM_MASTERS*BURST_W.
REQ-011 SHALL have: m_waitrequest  out  NUM_MASTERS; m_readdatavalid  out  NUM_MASTERS; m_readdata  out  DATA_W  shared read data.
REQ-012 SHALL have: s_address, s_read, s_write, s_writedata, s_byteenable, s_burstcount  out  widths as master slice; s_waitrequest, s_readdatavalid  in  1; s_readdata  in  DATA_W.

Function
REQ-013 SHALL use FSM states IDLE and WBURST; read commands and single-beat writes complete from IDLE.
REQ-014 In IDLE, SHALL grant combinationally, same cycle, the first requesting eligible master at or after round-robin pointer rr_ptr, wrapping NUM_MASTERS-1 -> 0.
REQ-015 A master is eligible if m_write=1, or m_read=1 and pending FIFO not full; m_read and m_write both high from one master: write wins.
REQ-016 SHALL drive all s_* command outputs from the granted master's slice; with no grant s_read=s_write=0, other s_* outputs 0.
REQ-017 m_waitrequest[k] SHALL be s_waitrequest for the granted master and 1 for every other master.
REQ-018 A command is accepted when (s_read|s_write)=1 and s_waitrequest=0; rr_ptr SHALL update to (granted+1) mod NUM_MASTERS only on acceptance of a read or of the final write beat.
REQ-019 On acceptance of a write first beat with burstcount>1, SHALL enter WBURST, latch grant, load beat counter = burstcount-1.
REQ-020 In WBURST, grant SHALL stay locked; counter decrements per accepted beat; at counter=1 with acceptance, return to IDLE; locked master deasserting m_write holds state (no beat consumed).
REQ-021 On read acceptance, SHALL push {master id, burstcount} to the pending FIFO; burstcount 0 SHALL be forwarded and tracked as 1 beat.
REQ-022 On s_readdatavalid=1, SHALL assert m_readdatavalid[id at FIFO head] for that cycle only, m_readdata = s_readdata combinationally, zero latency.
REQ-023 A response beat counter SHALL count head beats; on the last beat of the head burst, the FIFO pops.
REQ-024 Simultaneous push and pop SHALL both take effect; FIFO count unchanged; full with simultaneous pop: read still not eligible (full evaluated before pop).
REQ-025 s_readdatavalid with FIFO empty SHALL be dropped, no m_readdatavalid asserted, and a sticky error flag set (visible to bench via hierarchy only).
REQ-026 Write responses are not tracked; writes SHALL be granted regardless of pending reads.

Reset
REQ-027 On reset_reset_n=0, SHALL asynchronously set state=IDLE, rr_ptr=0, beat counters=0, FIFO empty, error flag=0.
REQ-028 During reset all m_readdatavalid=0, s_read=s_write=0, m_waitrequest=all ones.
REQ-029 Reset mid-burst or with reads pending SHALL discard all state; no response routed after release until new reads accepted.

Verification
REQ-030 Masters 0,1 both issue single write same cycle, s_waitrequest=0 -> master 0 accepted cycle 0, master 1 cycle 1, rr_ptr=0 after.
REQ-031 Master 1 write burst of 4 (addr 0x100), master 0 requests read during it -> 4 beats of master 1 contiguous on s_*, master 0 read issued cycle after final beat.
REQ-032 Master 0 read burst 8, then master 1 read burst 2; slave returns 10 beats with random gaps -> first 8 on m_readdatavalid[0], last 2 on [1], data matches.
REQ-033 MAX_PENDING=8 single reads outstanding -> 9th read held by m_waitrequest=1; write from other master still accepted; one response beat frees slot next cycle.
REQ-034 s_waitrequest=1 for 2 cycles per beat on burst write of 3 -> each beat held stable, grant locked, exactly 3 accepted beats.
REQ-035 Assert reset_reset_n=0 mid write burst (beat 2 of 8) with 3 reads pending -> next cycle IDLE, FIFO empty; stray s_readdatavalid after release raises error flag only.
